// File: rtl/mult_pkg.sv
// Shared types and elaboration helpers for the iterative multiplier.
//   state_t  : controller states (IDLE, CALC, FINISH)
//   width_ok : true when an operand width splits evenly into digits
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH
  } state_t;

  function automatic bit width_ok(int unsigned width, int unsigned subdiv);
    return (subdiv != 0) && (width != 0) && ((width % subdiv) == 0);
  endfunction

endpackage

// File: rtl/digit_mul.sv
// Combinational unsigned partial product: one multiplier digit times the
// (WIDTH+1)-bit multiplicand magnitude.
//   digit : SUBDIV_SIZE-bit multiplier digit
//   mcand : WIDTH+1-bit multiplicand magnitude
//   pp    : full-width unsigned product
module digit_mul #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SUBDIV_SIZE = 4
) (
  input  logic [SUBDIV_SIZE-1:0]     digit,
  input  logic [WIDTH:0]             mcand,
  output logic [WIDTH+SUBDIV_SIZE:0] pp
);

  localparam int unsigned PPW = WIDTH + SUBDIV_SIZE + 1;

  assign pp = PPW'(digit) * PPW'(mcand);

endmodule

// File: rtl/iter_multiplier.sv
// Iterative sign-magnitude multiplier. Consumes one SUBDIV_SIZE-bit digit
// of the multiplier per CALC cycle, N = WIDTH/SUBDIV_SIZE cycles per product.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, accepted only in IDLE
//   is_signed  : operands are two's complement when high
//   a, b       : multiplicand, multiplier (captured on accept)
//   busy       : high while an operation is in flight
//   done       : one-cycle pulse when product is updated
//   product    : registered 2*WIDTH-bit result
module iter_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SUBDIV_SIZE = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned N  = WIDTH / SUBDIV_SIZE;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned MW = WIDTH + 1;
  localparam int unsigned DW = WIDTH + SUBDIV_SIZE + 1;

  if (!width_ok(WIDTH, SUBDIV_SIZE)) begin : g_width_check
    $error("iter_multiplier: WIDTH must be a non-zero multiple of SUBDIV_SIZE");
  end

  state_t          state, state_next;
  logic [MW-1:0]   mag_a, mag_b;
  logic [MW-1:0]   mag_a_in, mag_b_in;
  logic            neg;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   pp_shifted;
  logic [DW-1:0]   pp;
  logic [CW-1:0]   cnt;
  logic            last_digit;

  // Magnitudes carry one extra bit so |-2^(WIDTH-1)| is representable.
  assign mag_a_in = (is_signed && a[WIDTH-1]) ? (~{1'b1, a}) + MW'(1) : {1'b0, a};
  assign mag_b_in = (is_signed && b[WIDTH-1]) ? (~{1'b1, b}) + MW'(1) : {1'b0, b};

  assign last_digit = (cnt == CW'(N - 1));
  assign busy       = (state != IDLE);

  // mag_b is shifted right each CALC cycle, so the current digit is
  // always its low SUBDIV_SIZE bits.
  digit_mul #(
    .WIDTH       (WIDTH),
    .SUBDIV_SIZE (SUBDIV_SIZE)
  ) u_digit_mul (
    .digit (mag_b[SUBDIV_SIZE-1:0]),
    .mcand (mag_a),
    .pp    (pp)
  );

  // Bits shifted beyond 2*WIDTH are dropped; the result is modulo 2^(2*WIDTH).
  assign pp_shifted = PW'(pp) << (cnt * SUBDIV_SIZE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (last_digit) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_a   <= '0;
      mag_b   <= '0;
      neg     <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mag_a <= mag_a_in;
            mag_b <= mag_b_in;
            neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc   <= '0;
            cnt   <= '0;
          end
        end
        CALC: begin
          acc   <= acc + pp_shifted;
          mag_b <= mag_b >> SUBDIV_SIZE;
          cnt   <= cnt + CW'(1);
        end
        FINISH: begin
          product <= neg ? ('0 - acc) : acc;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_multiplier.sv
module tb_iter_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, is_signed;
  logic [7:0]  a, b;
  logic        busy, done;
  logic [15:0] product;

  int checks   = 0;
  int failures = 0;

  iter_multiplier #(.WIDTH(8), .SUBDIV_SIZE(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .product(product)
  );

  // WIDTH=16 sweep: instance g uses SUBDIV_SIZE = 2^g (1,2,4,8,16).
  logic        sw_start [5];
  logic        sw_signed;
  logic [15:0] sw_a, sw_b;
  logic        sw_busy  [5];
  logic        sw_done  [5];
  logic [31:0] sw_prod  [5];

  for (genvar g = 0; g < 5; g++) begin : g_sweep
    iter_multiplier #(.WIDTH(16), .SUBDIV_SIZE(1 << g)) dut_sw (
      .clk(clk), .rst_n(rst_n), .start(sw_start[g]), .is_signed(sw_signed),
      .a(sw_a), .b(sw_b), .busy(sw_busy[g]), .done(sw_done[g]), .product(sw_prod[g])
    );
  end

  // Reference: exact integer product, reduced modulo 2^(2w).
  function automatic logic [31:0] ref_mul(int w, logic s, logic [15:0] x, logic [15:0] y);
    longint mask, sx, sy, p;
    mask = (longint'(1) << w) - 1;
    sx = longint'(x) & mask;
    sy = longint'(y) & mask;
    if (s && sx[w-1]) sx = sx - (longint'(1) << w);
    if (s && sy[w-1]) sy = sy - (longint'(1) << w);
    p = (sx * sy) & ((longint'(1) << (2 * w)) - 1);
    return p[31:0];
  endfunction

  // Drives one operation and observes it for 8 edges; operands are
  // scrambled right after the accepting edge.
  task automatic do_op(input logic s, input logic [7:0] aa, input logic [7:0] bb,
                       output int lat, output int bcyc, output int dcnt,
                       output logic [15:0] prod);
    lat = 0; bcyc = 0; dcnt = 0; prod = '0;
    @(negedge clk);
    start = 1'b1; is_signed = s; a = aa; b = bb;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      if (e == 1) begin
        start = 1'b0; a = 8'($urandom); b = 8'($urandom); is_signed = 1'($urandom);
      end
      if (busy) bcyc++;
      if (done) begin
        dcnt++;
        if (lat == 0) begin lat = e; prod = product; end
      end
    end
  endtask

  task automatic test_reset;
    int lat;
    lat = 0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (product !== 16'd0) begin failures++; $display("FAIL reset_product got=%0d exp=0", product); end
    checks++; if (sw_prod[2] !== 32'd0) begin failures++; $display("FAIL reset_sweep_product got=%0d exp=0", sw_prod[2]); end
    // Release reset and request on the same cycle: first edge accepts.
    rst_n = 1'b1; start = 1'b1; is_signed = 1'b0; a = 8'd22; b = 8'd30;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      if (e == 1) start = 1'b0;
      if (done && lat == 0) lat = e;
    end
    checks++; if (lat !== 4) begin failures++; $display("FAIL first_start_latency got=%0d exp=4", lat); end
    checks++; if (product !== 16'd660) begin failures++; $display("FAIL first_start_product got=%0d exp=660", product); end
  endtask

  task automatic test_basic;
    int lat, bc, dc; logic [15:0] p;
    do_op(1'b0, 8'd22, 8'd30, lat, bc, dc, p);
    checks++; if (p !== 16'd660) begin failures++; $display("FAIL basic_product got=%0d exp=660", p); end
    checks++; if (lat !== 4) begin failures++; $display("FAIL basic_latency got=%0d exp=4", lat); end
    checks++; if (bc !== 3) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=3", bc); end
    checks++; if (dc !== 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", dc); end
  endtask

  task automatic test_directed;
    int lat, bc, dc; logic [15:0] p;
    do_op(1'b1, 8'hFB, 8'd7, lat, bc, dc, p);
    checks++; if (p !== 16'hFFDD) begin failures++; $display("FAIL signed_m5x7 got=%h exp=ffdd", p); end
    do_op(1'b1, 8'h80, 8'h80, lat, bc, dc, p);
    checks++; if (p !== 16'd16384) begin failures++; $display("FAIL signed_m128xm128 got=%0d exp=16384", p); end
    checks++; if (lat !== 4) begin failures++; $display("FAIL signed_latency got=%0d exp=4", lat); end
    do_op(1'b0, 8'd255, 8'd255, lat, bc, dc, p);
    checks++; if (p !== 16'd65025) begin failures++; $display("FAIL unsigned_255x255 got=%0d exp=65025", p); end
  endtask

  task automatic test_start_ignored;
    int lat, dc;
    lat = 0; dc = 0;
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; a = 8'd22; b = 8'd30;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      if (e == 1) begin a = 8'd1; b = 8'd1; end   // start still high during CALC
      if (e == 2) start = 1'b0;
      if (done) begin dc++; if (lat == 0) lat = e; end
    end
    checks++; if (product !== 16'd660) begin failures++; $display("FAIL ignore_product got=%0d exp=660", product); end
    checks++; if (dc !== 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", dc); end
    checks++; if (lat !== 4) begin failures++; $display("FAIL ignore_latency got=%0d exp=4", lat); end
  endtask

  task automatic test_reset_mid;
    int dc, lat, bc; logic [15:0] p;
    dc = 0;
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; a = 8'd22; b = 8'd30;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    checks++; if (product !== 16'd0) begin failures++; $display("FAIL midreset_product got=%0d exp=0", product); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (done) dc++;
    end
    checks++; if (dc !== 0) begin failures++; $display("FAIL midreset_no_done got=%0d exp=0", dc); end
    checks++; if (product !== 16'd0) begin failures++; $display("FAIL midreset_product_held got=%0d exp=0", product); end
    do_op(1'b0, 8'd3, 8'd4, lat, bc, dc, p);
    checks++; if (p !== 16'd12) begin failures++; $display("FAIL after_reset_product got=%0d exp=12", p); end
    checks++; if (lat !== 4) begin failures++; $display("FAIL after_reset_latency got=%0d exp=4", lat); end
  endtask

  task automatic test_back_to_back;
    int de[$];
    logic [15:0] dp[$];
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; a = 8'd22; b = 8'd30;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      if (e == 1) begin a = 8'd10; b = 8'd10; end   // start stays high
      if (e == 5) start = 1'b0;
      if (done) begin de.push_back(e); dp.push_back(product); end
    end
    checks++; if (de.size() !== 2) begin failures++; $display("FAIL b2b_done_count got=%0d exp=2", de.size()); end
    if (de.size() == 2) begin
      checks++; if (de[1] - de[0] !== 4) begin failures++; $display("FAIL b2b_spacing got=%0d exp=4", de[1] - de[0]); end
      checks++; if (de[0] !== 4) begin failures++; $display("FAIL b2b_first_edge got=%0d exp=4", de[0]); end
      checks++; if (dp[0] !== 16'd660) begin failures++; $display("FAIL b2b_first_product got=%0d exp=660", dp[0]); end
      checks++; if (dp[1] !== 16'd100) begin failures++; $display("FAIL b2b_second_product got=%0d exp=100", dp[1]); end
    end
  endtask

  task automatic test_random_main;
    int lat, bc, dc; logic [15:0] p, exp_p;
    logic [7:0] cv [4];
    logic [7:0] aa, bb; logic s;
    cv = '{8'h00, 8'h80, 8'h7F, 8'hFF};
    for (int i = 0; i < 200; i++) begin
      if (i < 32) begin
        aa = cv[i % 4]; bb = cv[(i / 4) % 4]; s = (i >= 16);
      end else begin
        aa = 8'($urandom); bb = 8'($urandom); s = 1'($urandom);
      end
      exp_p = ref_mul(8, s, {8'd0, aa}, {8'd0, bb})[15:0];
      do_op(s, aa, bb, lat, bc, dc, p);
      checks++;
      if (p !== exp_p || lat !== 4 || dc !== 1) begin
        failures++;
        $display("FAIL rand8 s=%0d a=%h b=%h got=%h lat=%0d dones=%0d exp=%h lat=4 dones=1",
                 s, aa, bb, p, lat, dc, exp_p);
      end
    end
  endtask

  task automatic test_sweep;
    int lat, exp_lat;
    logic [15:0] x, y; logic s;
    logic [31:0] exp_p;
    for (int k = 0; k < 5; k++) begin
      exp_lat = (16 >> k) + 2;
      for (int n = 0; n < 200; n++) begin
        s = n[0];
        if (n < 2) begin x = 16'h8000; y = 16'h8000; end
        else if (n < 4) begin x = 16'hFFFF; y = 16'h7FFF; end
        else begin x = 16'($urandom); y = 16'($urandom); end
        exp_p = ref_mul(16, s, x, y);
        @(negedge clk);
        sw_start[k] = 1'b1; sw_signed = s; sw_a = x; sw_b = y;
        lat = 0;
        for (int e = 1; e <= 24; e++) begin
          @(negedge clk);
          if (e == 1) begin
            sw_start[k] = 1'b0; sw_a = 16'($urandom); sw_b = 16'($urandom); sw_signed = ~s;
          end
          if (sw_done[k]) begin lat = e; break; end
        end
        checks++;
        if (lat !== exp_lat) begin
          failures++; $display("FAIL sweep_latency sub=%0d got=%0d exp=%0d", 1 << k, lat, exp_lat);
        end
        checks++;
        if (sw_prod[k] !== exp_p) begin
          failures++;
          $display("FAIL sweep_product sub=%0d s=%0d a=%h b=%h got=%h exp=%h", 1 << k, s, x, y, sw_prod[k], exp_p);
        end
        checks++;
        if (sw_busy[k] !== 1'b0) begin
          failures++; $display("FAIL sweep_busy_at_done sub=%0d got=%b exp=0", 1 << k, sw_busy[k]);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    sw_signed = 1'b0; sw_a = '0; sw_b = '0;
    for (int i = 0; i < 5; i++) sw_start[i] = 1'b0;
    test_reset;
    test_basic;
    test_directed;
    test_start_ignored;
    test_reset_mid;
    test_back_to_back;
    test_random_main;
    test_sweep;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
